// File: rtl/wash_run_sequencer.sv
// Washing-machine state controller: 7-state FSM plus the per-phase countdown word fed to the view stage.
// Latency 1 cycle from any input to state/msg; no backpressure, every input is sampled on every cp edge.
module wash_run_sequencer #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int BEGIN_TICKS  = 2,
  parameter int FINISH_TICKS = 5
) (
  input  logic        cp,
  input  logic        rst_n,
  input  logic        power,
  input  logic        start_pause,
  input  logic        lid_open,
  input  logic [25:0] source,
  output logic [2:0]  state,
  output logic [25:0] msg,
  output logic        alarm,
  output logic        phase_done
);

  typedef enum logic [2:0] {
    st_shutdown = 3'd0,
    st_begin    = 3'd1,
    st_set      = 3'd2,
    st_run      = 3'd3,
    st_error    = 3'd4,
    st_pause    = 3'd5,
    st_finish   = 3'd6
  } st_t;

  localparam int CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (BEGIN_TICKS > FINISH_TICKS) ? BEGIN_TICKS : FINISH_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  // Field layout, most significant (first phase) first.
  localparam int FLO [8] = '{23, 19, 16, 13, 10, 6, 3, 0};
  localparam int FW  [8] = '{3, 4, 3, 3, 3, 4, 3, 3};

  st_t           st;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [25:0]   dec_msg;
  logic          dec_zero;
  logic          found;
  logic [25:0]   fv;

  assign state = st;
  assign tick  = (cnt == CW'(TICK_DIV - 1));

  // Subtracting one at the LSB of a nonzero field can never borrow out of it.
  always_comb begin
    dec_msg  = msg;
    dec_zero = 1'b0;
    found    = 1'b0;
    fv       = '0;
    for (int i = 0; i < 8; i++) begin
      fv = (msg >> FLO[i]) & ((26'd1 << FW[i]) - 26'd1);
      if (!found && fv != 26'd0) begin
        found    = 1'b1;
        dec_msg  = msg - (26'd1 << FLO[i]);
        dec_zero = (fv == 26'd1);
      end
    end
  end

  always_ff @(posedge cp) begin
    if (!rst_n) begin
      st         <= st_shutdown;
      msg        <= '0;
      alarm      <= 1'b0;
      phase_done <= 1'b0;
      cnt        <= '0;
      tcnt       <= '0;
    end else begin
      phase_done <= 1'b0;
      if (power) begin
        st    <= (st == st_shutdown) ? st_begin : st_shutdown;
        msg   <= '0;
        alarm <= 1'b0;
        cnt   <= '0;
        tcnt  <= '0;
      end else begin
        case (st)
          st_shutdown: begin
            msg   <= '0;
            alarm <= 1'b0;
            cnt   <= '0;
            tcnt  <= '0;
          end
          st_begin: begin
            if (tick) begin
              cnt <= '0;
              if (tcnt == TW'(BEGIN_TICKS - 1)) begin
                st   <= st_set;
                tcnt <= '0;
              end else begin
                tcnt <= tcnt + TW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          st_set: begin
            cnt  <= '0;
            tcnt <= '0;
            if (start_pause && source != 26'd0 && !lid_open) begin
              st  <= st_run;
              msg <= source;
            end
          end
          st_run: begin
            // Leaving run freezes the partial tick count so a resume picks up where it stopped.
            if (lid_open) begin
              st    <= st_error;
              alarm <= 1'b1;
            end else if (start_pause) begin
              st <= st_pause;
            end else if (tick) begin
              cnt        <= '0;
              msg        <= dec_msg;
              phase_done <= dec_zero;
              if (dec_msg == 26'd0) begin
                st    <= st_finish;
                alarm <= 1'b1;
                tcnt  <= '0;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          st_pause: begin
            if (lid_open) begin
              st    <= st_error;
              alarm <= 1'b1;
            end else if (start_pause) begin
              st <= st_run;
            end
          end
          st_error: begin
            if (!lid_open) begin
              st    <= st_pause;
              alarm <= 1'b0;
            end
          end
          st_finish: begin
            if (tick) begin
              cnt <= '0;
              if (tcnt == TW'(FINISH_TICKS - 1)) begin
                st    <= st_shutdown;
                msg   <= '0;
                alarm <= 1'b0;
                tcnt  <= '0;
              end else begin
                tcnt <= tcnt + TW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            st    <= st_shutdown;
            msg   <= '0;
            alarm <= 1'b0;
            cnt   <= '0;
            tcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wash_run_sequencer.sv
// Directed bench for wash_run_sequencer with TICK_DIV=4, BEGIN_TICKS=2, FINISH_TICKS=3.
module tb_wash_run_sequencer;
  logic        cp = 1'b0;
  logic        rst_n;
  logic        power;
  logic        start_pause;
  logic        lid_open;
  logic [25:0] source;
  logic [2:0]  state;
  logic [25:0] msg;
  logic        alarm;
  logic        phase_done;

  int total = 0;
  int bad   = 0;

  wash_run_sequencer #(
    .TICK_DIV    (4),
    .BEGIN_TICKS (2),
    .FINISH_TICKS(3)
  ) dut (
    .cp         (cp),
    .rst_n      (rst_n),
    .power      (power),
    .start_pause(start_pause),
    .lid_open   (lid_open),
    .source     (source),
    .state      (state),
    .msg        (msg),
    .alarm      (alarm),
    .phase_done (phase_done)
  );

  always #5 cp = ~cp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge cp);
    #1;
  endtask

  task automatic pulse_start();
    start_pause = 1'b1;
    step(1);
    start_pause = 1'b0;
  endtask

  task automatic pulse_power();
    power = 1'b1;
    step(1);
    power = 1'b0;
  endtask

  task automatic go_to_set();
    pulse_power();
    step(8);
    check_eq("enter_set", 32'(state), 32'd2);
  endtask

  initial begin
    rst_n       = 1'b0;
    power       = 1'b0;
    start_pause = 1'b0;
    lid_open    = 1'b0;
    source      = '0;
    step(2);
    rst_n = 1'b1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_msg", 32'(msg), 32'd0);
    check_eq("rst_alarm", 32'(alarm), 32'd0);
    check_eq("rst_pdone", 32'(phase_done), 32'd0);

    // Power up: eight cycles in begin, then set.
    pulse_power();
    check_eq("begin_first", 32'(state), 32'd1);
    for (int i = 0; i < 7; i++) begin
      step(1);
      check_eq("begin_hold", 32'(state), 32'd1);
    end
    step(1);
    check_eq("begin_to_set", 32'(state), 32'd2);
    pulse_start();
    check_eq("set_zero_src", 32'(state), 32'd2);
    source = 26'h0000003;
    pulse_start();
    check_eq("run_state", 32'(state), 32'd3);
    check_eq("run_load", 32'(msg), 32'h3);

    // Countdown 3,2,1,0 on a tick every 4 cycles, then finish for 12 cycles.
    step(4);
    check_eq("cd_msg2", 32'(msg), 32'h2);
    check_eq("cd_pd2", 32'(phase_done), 32'd0);
    step(4);
    check_eq("cd_msg1", 32'(msg), 32'h1);
    step(3);
    check_eq("cd_hold1", 32'(msg), 32'h1);
    step(1);
    check_eq("cd_msg0", 32'(msg), 32'h0);
    check_eq("cd_pd0", 32'(phase_done), 32'd1);
    check_eq("cd_finish", 32'(state), 32'd6);
    check_eq("cd_alarm", 32'(alarm), 32'd1);
    step(1);
    check_eq("pd_one_cycle", 32'(phase_done), 32'd0);
    step(10);
    check_eq("fin_hold", 32'(state), 32'd6);
    step(1);
    check_eq("fin_shutdown", 32'(state), 32'd0);
    check_eq("fin_msg", 32'(msg), 32'd0);
    check_eq("fin_alarm", 32'(alarm), 32'd0);

    // Highest nonzero field first, no borrow through the zero middle fields.
    go_to_set();
    source = 26'h0800001;
    pulse_start();
    check_eq("f_load", 32'(msg), 32'h0800001);
    step(4);
    check_eq("f_msg_top", 32'(msg), 32'h0000001);
    check_eq("f_pd_top", 32'(phase_done), 32'd1);
    check_eq("f_state_top", 32'(state), 32'd3);
    step(4);
    check_eq("f_msg_last", 32'(msg), 32'h0);
    check_eq("f_pd_last", 32'(phase_done), 32'd1);
    check_eq("f_finish", 32'(state), 32'd6);
    pulse_power();
    check_eq("f_pwr_off", 32'(state), 32'd0);

    // Lid opens on a tick cycle; partial count survives error/pause.
    go_to_set();
    source = 26'h0000012;
    pulse_start();
    step(3);
    lid_open = 1'b1;
    step(1);
    check_eq("lid_error", 32'(state), 32'd4);
    check_eq("lid_msg", 32'(msg), 32'h12);
    check_eq("lid_alarm", 32'(alarm), 32'd1);
    step(2);
    check_eq("err_hold", 32'(state), 32'd4);
    lid_open = 1'b0;
    step(1);
    check_eq("err_to_pause", 32'(state), 32'd5);
    check_eq("pause_alarm", 32'(alarm), 32'd0);
    step(2);
    check_eq("pause_msg", 32'(msg), 32'h12);
    pulse_start();
    check_eq("resume_run", 32'(state), 32'd3);
    check_eq("resume_msg", 32'(msg), 32'h12);
    step(1);
    check_eq("resume_tick", 32'(msg), 32'h0A);
    check_eq("resume_pd", 32'(phase_done), 32'd0);
    step(3);
    check_eq("resume_hold", 32'(msg), 32'h0A);
    step(1);
    check_eq("resume_tick2", 32'(msg), 32'h02);
    check_eq("resume_pd2", 32'(phase_done), 32'd1);

    // Pause wins over a coincident tick; power in pause shuts down.
    step(3);
    pulse_start();
    check_eq("sp_tick_pause", 32'(state), 32'd5);
    check_eq("sp_tick_msg", 32'(msg), 32'h02);
    pulse_power();
    check_eq("pause_pwr", 32'(state), 32'd0);
    check_eq("pause_pwr_msg", 32'(msg), 32'd0);

    // Reset in the middle of a run.
    go_to_set();
    source = 26'h0000009;
    pulse_start();
    step(2);
    check_eq("mid_run_msg", 32'(msg), 32'h9);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_eq("mid_rst_state", 32'(state), 32'd0);
    check_eq("mid_rst_msg", 32'(msg), 32'd0);
    check_eq("mid_rst_alarm", 32'(alarm), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
